// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: compares decoded bits against source bits buffered in an elastic FIFO
// Build option: define VITERBI_BER_RUN_EN to enable consecutive-error run tracking (max_run_o).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src_valid_i/bit_i   source bit entering the encoder (pushed into the FIFO)
//   dec_valid_i/bit_i   decoded bit leaving the decoder (pops and compares FIFO head)
//   clear_i             synchronous soft clear, same effect as rst
//   checking_o          high once the leading SKIP bits have been discarded
//   level_o             FIFO occupancy
//   bit_ct_o, err_ct_o  saturating compared / mismatched bit counts
//   err_o               one-cycle pulse after each mismatch
//   max_run_o           longest run of consecutive mismatches
//   ovf_o, udf_o        sticky overflow / underflow flags
module viterbi_ber_checker #(
   parameter int DEPTH = 64,
   parameter int SKIP = 0,
   parameter int CNT_W = 32,
   parameter int RUN_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     src_valid_i,
   input  logic                     src_bit_i,
   input  logic                     dec_valid_i,
   input  logic                     dec_bit_i,
   input  logic                     clear_i,
   output logic                     checking_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [CNT_W-1:0]         bit_ct_o,
   output logic [CNT_W-1:0]         err_ct_o,
   output logic                     err_o,
   output logic [RUN_W-1:0]         max_run_o,
   output logic                     ovf_o,
   output logic                     udf_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = SKIP > 0 ? $clog2(SKIP + 1) : 1;
   typedef enum logic {S_SKIP, S_CHECK} state_t;
   state_t state;
   logic [DEPTH-1:0] mem;
   logic [AW:0] wp, rp;
   logic [SW-1:0] skip_ct;
   logic full, empty, push, pop, cmp, mis;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty = wp == rp;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push = src_valid_i && (!full || pop);
   assign pop = dec_valid_i && !empty;
   assign cmp = pop && state == S_CHECK;
   assign mis = cmp && (mem[rp[AW-1:0]] != dec_bit_i);
   assign checking_o = state == S_CHECK;
   assign level_o = wp - rp;
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= src_bit_i;
   always_ff @(posedge clk)
      if (rst || clear_i) begin
         wp <= '0;
         rp <= '0;
         state <= SKIP == 0 ? S_CHECK : S_SKIP;
         skip_ct <= SW'(SKIP);
         bit_ct_o <= '0;
         err_ct_o <= '0;
         err_o <= 1'b0;
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (src_valid_i && !push) ovf_o <= 1'b1;
         if (dec_valid_i && empty) udf_o <= 1'b1;
         err_o <= mis;
         if (pop && state == S_SKIP) begin
            skip_ct <= skip_ct - 1'b1;
            if (skip_ct == SW'(1)) state <= S_CHECK;
         end
         if (cmp) bit_ct_o <= bit_ct_o + CNT_W'(bit_ct_o != '1);
         if (mis) err_ct_o <= err_ct_o + CNT_W'(err_ct_o != '1);
      end
`ifdef VITERBI_BER_RUN_EN
   logic [RUN_W-1:0] run, run_nx;
   assign run_nx = run + RUN_W'(run != '1);
   always_ff @(posedge clk)
      if (rst || clear_i) begin
         run <= '0;
         max_run_o <= '0;
      end else if (cmp) begin
         run <= mis ? run_nx : '0;
         if (mis && run_nx > max_run_o) max_run_o <= run_nx;
      end
`else
   assign max_run_o = '0;
`endif
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker: directed self-checking bench for viterbi_ber_checker (SKIP=0 and SKIP=4 instances)
module tb_viterbi_ber_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, clr, sv, sb, dv, db;
   logic chk0, err0, ovf0, udf0, chk4, err4, ovf4, udf4;
   logic [6:0] lvl0, lvl4;
   logic [31:0] bct0, ect0, bct4, ect4;
   logic [7:0] mr0, mr4;
   int checks = 0, errors = 0, pulses;
   logic [63:0] pat = 64'hA5C3_1F0E_96D2_7B48;
   logic [99:0] inv;
`ifdef VITERBI_BER_RUN_EN
   localparam logic [31:0] EXP_RUN = 3;
`else
   localparam logic [31:0] EXP_RUN = 0;
`endif

   viterbi_ber_checker #(.DEPTH(64), .SKIP(0)) u0 (
      .clk(clk), .rst(rst), .src_valid_i(sv), .src_bit_i(sb), .dec_valid_i(dv), .dec_bit_i(db),
      .clear_i(clr), .checking_o(chk0), .level_o(lvl0), .bit_ct_o(bct0), .err_ct_o(ect0),
      .err_o(err0), .max_run_o(mr0), .ovf_o(ovf0), .udf_o(udf0));
   viterbi_ber_checker #(.DEPTH(64), .SKIP(4)) u4 (
      .clk(clk), .rst(rst), .src_valid_i(sv), .src_bit_i(sb), .dec_valid_i(dv), .dec_bit_i(db),
      .clear_i(clr), .checking_o(chk4), .level_o(lvl4), .bit_ct_o(bct4), .err_ct_o(ect4),
      .err_o(err4), .max_run_o(mr4), .ovf_o(ovf4), .udf_o(udf4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_n(input int n, input int off);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sv = 1'b1; sb = pat[(i + off) % 64]; dv = 1'b0;
      end
      @(negedge clk);
      sv = 1'b0;
   endtask

   task automatic pop_n(input int n, input int off);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sv = 1'b0; dv = 1'b1; db = pat[(i + off) % 64];
      end
      @(negedge clk);
      dv = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clr = 1'b1; sv = 1'b1; dv = 1'b1;
      @(negedge clk);
      clr = 1'b0; sv = 1'b0; dv = 1'b0;
   endtask

   task automatic stream(input logic [99:0] mask, output int np);
      logic s [100];
      np = 0;
      for (int i = 0; i < 100; i++) s[i] = 1'($urandom);
      for (int c = 0; c < 112; c++) begin
         @(negedge clk);
         if (err0) np++;
         sv = c < 100;
         sb = c < 100 ? s[c] : 1'b0;
         dv = c >= 12;
         db = c >= 12 ? s[c-12] ^ mask[c-12] : 1'b0;
      end
      @(negedge clk);
      if (err0) np++;
      sv = 1'b0; dv = 1'b0;
      @(negedge clk);
      if (err0) np++;
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_level"}, 32'(lvl0), 0);
      check({tag, "_bit_ct"}, bct0, 0);
      check({tag, "_err_ct"}, ect0, 0);
      check({tag, "_err"}, 32'(err0), 0);
      check({tag, "_max_run"}, 32'(mr0), 0);
      check({tag, "_ovf"}, 32'(ovf0), 0);
      check({tag, "_udf"}, 32'(udf0), 0);
      check({tag, "_checking"}, 32'(chk0), 1);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; sv = 1'b0; sb = 1'b0; dv = 1'b0; db = 1'b0;
      // reset with valids asserted
      @(negedge clk);
      rst = 1'b1; sv = 1'b1; dv = 1'b1; sb = 1'b1; db = 1'b0;
      @(negedge clk);
      @(negedge clk);
      all_zero("reset");
      check("reset_checking_skip4", 32'(chk4), 0);
      check("reset_level_skip4", 32'(lvl4), 0);
      rst = 1'b0; sv = 1'b0; dv = 1'b0;
      // clean loopback
      stream('0, pulses);
      check("loop_bit_ct", bct0, 100);
      check("loop_err_ct", ect0, 0);
      check("loop_err_pulses", 32'(pulses), 0);
      check("loop_level", 32'(lvl0), 0);
      check("loop_udf", 32'(udf0), 0);
      check("loop_ovf", 32'(ovf0), 0);
      // mid-stream clear
      push_n(5, 0);
      check("mid_level", 32'(lvl0), 5);
      pulse_clear();
      all_zero("clear");
      // burst errors on decoded bits 5,6,7,20
      inv = '0;
      inv[5] = 1'b1; inv[6] = 1'b1; inv[7] = 1'b1; inv[20] = 1'b1;
      stream(inv, pulses);
      check("burst_bit_ct", bct0, 100);
      check("burst_err_ct", ect0, 4);
      check("burst_max_run", 32'(mr0), EXP_RUN);
      check("burst_err_pulses", 32'(pulses), 4);
      check("burst_level", 32'(lvl0), 0);
      // overflow
      pulse_clear();
      push_n(64, 0);
      check("full_level", 32'(lvl0), 64);
      check("full_no_ovf", 32'(ovf0), 0);
      push_n(1, 0);
      check("ovf_level", 32'(lvl0), 64);
      check("ovf_flag", 32'(ovf0), 1);
      pop_n(64, 0);
      check("ovf_drain_err_ct", ect0, 0);
      check("ovf_drain_bit_ct", bct0, 64);
      check("ovf_drain_level", 32'(lvl0), 0);
      // simultaneous push+pop while full
      pulse_clear();
      push_n(64, 0);
      @(negedge clk);
      sv = 1'b1; sb = 1'b0; dv = 1'b1; db = pat[0];
      @(negedge clk);
      sv = 1'b0; dv = 1'b0;
      check("full_pp_level", 32'(lvl0), 64);
      check("full_pp_ovf", 32'(ovf0), 0);
      check("full_pp_bit_ct", bct0, 1);
      check("full_pp_err_ct", ect0, 0);
      // underflow
      pulse_clear();
      @(negedge clk);
      dv = 1'b1; db = 1'b1;
      @(negedge clk);
      dv = 1'b0;
      check("udf_flag", 32'(udf0), 1);
      check("udf_bit_ct", bct0, 0);
      check("udf_level", 32'(lvl0), 0);
      @(negedge clk);
      sv = 1'b1; sb = 1'b1; dv = 1'b1; db = 1'b1;
      @(negedge clk);
      sv = 1'b0; dv = 1'b0;
      check("empty_pp_level", 32'(lvl0), 1);
      check("empty_pp_bit_ct", bct0, 0);
      // SKIP=4: 10 matched pairs
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("skip_checking_reset", 32'(chk4), 0);
      push_n(10, 0);
      pop_n(3, 0);
      check("skip_checking_3", 32'(chk4), 0);
      check("skip_bit_ct_3", bct4, 0);
      pop_n(1, 3);
      check("skip_checking_4", 32'(chk4), 1);
      check("skip_bit_ct_4", bct4, 0);
      pop_n(6, 4);
      check("skip_bit_ct", bct4, 6);
      check("skip_err_ct", ect4, 0);
      check("skip_level", 32'(lvl4), 0);
      check("noskip_bit_ct", bct0, 10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate checker for the convolutional-encoder / channel / Viterbi-decoder chain. It captures the raw source bits presented to the encoder in an elastic FIFO. It then pops and compares one source bit against each decoded bit leaving the decoder. It reports compared-bit count, error count, longest consecutive error run and FIFO overflow/underflow. It sits beside the decoder and absorbs the decoder's pipeline/traceback latency without needing that latency as a parameter.

## Interface
- `DEPTH`, 64: source FIFO depth in bits. Power of two, ≥ 4. Must exceed decoder latency in cycles.
- `SKIP`, 0: number of leading decoded bits popped and discarded (not counted) after reset/clear.
- `CNT_W`, 32: width of `bit_ct_o` / `err_ct_o`.
- `RUN_W`, 8: width of run-length tracking.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `src_valid_i`  in  1  source bit valid (same cycle it enters the encoder).
- `src_bit_i`  in  1  source bit.
- `dec_valid_i`  in  1  decoded bit valid.
- `dec_bit_i`  in  1  decoded bit.
- `clear_i`  in  1  synchronous soft clear, same effect as `rst`.
- `checking_o`  out  1  state is CHECK.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `bit_ct_o`  out  CNT_W  compared bits, saturating.
- `err_ct_o`  out  CNT_W  mismatched bits, saturating.
- `err_o`  out  1  one-cycle pulse per mismatch.
- `max_run_o`  out  RUN_W  longest run of consecutive mismatches.
- `ovf_o`  out  1  sticky: source bit dropped, FIFO full.
- `udf_o`  out  1  sticky: decoded bit arrived, FIFO empty.

## Operation
- FIFO: write/read pointers $clog2(DEPTH)+1 bits wide. Full when MSBs differ and the rest are equal; empty when the pointers are equal.
- Push when `src_valid_i` && !full. `src_valid_i` while full drops the bit and sets `ovf_o`.
- Pop when `dec_valid_i` && !empty. `dec_valid_i` while empty pops nothing, compares nothing and sets `udf_o`.
- Simultaneous push+pop while full: both occur, level unchanged, no overflow.
- Simultaneous push+pop while empty: no pass-through. The push occurs, the decoded bit is an underflow, and level becomes 1.
- State machine, two states:
  - SKIP: entered on reset/clear when SKIP>0. Each pop decrements a skip counter and performs no compare. On the pop that brings the counter to 0, move to CHECK.
  - CHECK: entered directly on reset/clear when SKIP=0. Each pop compares FIFO head with `dec_bit_i`. A pair is a mismatch if the bits differ.
- Counters (CHECK only):
  - `bit_ct_o` +1 per compare.
  - `err_ct_o` +1 per mismatch.
  - Both hold at all-ones (saturating).
- Run tracking: internal run counter +1 per mismatch (saturating at 2^RUN_W−1). It resets to 0 on a matching compare. Cycles without a pop leave it unchanged. `max_run_o` takes the new run value whenever that value exceeds it.
- `err_o` is registered: high for exactly the cycle after each mismatching compare.
- `rst` and `clear_i`:
  - Priority: `rst` > `clear_i` > normal operation.
  - Both empty the FIFO, zero all counters and flags, and reload the skip counter.
  - Inputs presented in the same cycle are ignored.
  - Mid-stream clear discards in-flight bits. The decoder stream must restart aligned.

## Timing
- Reset values: `checking_o` = (SKIP==0), all other outputs 0.
- `level_o`, counters, `err_o`, `max_run_o`, flags, and the SKIP→CHECK transition all update at the edge that accepts the input. They are visible the following cycle (1-cycle latency).
- Mismatch at edge N: `err_ct_o` and `max_run_o` change and `err_o` is high during cycle N+1.
- FIFO read is combinational from the head entry. No read latency is added to the compare.

## Configuration
- `VITERBI_BER_RUN_EN`:
  - Defined: run counter and `max_run_o` logic are compiled in as specified.
  - Undefined: that logic is omitted and `max_run_o` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset/clear: assert `rst` 2 cycles with valids high → all outputs 0, `level_o`=0. Repeat mid-stream with `clear_i` → same result next cycle.
- Clean loopback (SKIP=0): 100 source bits; decoder echoes them 12 cycles later → `bit_ct_o`=100, `err_ct_o`=0, `err_o` never high, final `level_o`=0.
- Burst errors: invert decoded bits 5,6,7 and 20 of 100 → `err_ct_o`=4, `max_run_o`=3 (0 if macro undefined), `err_o` pulses 4 times.
- Overflow (DEPTH=64): 65 pushes, no pops → `level_o`=64, `ovf_o`=1. Then 64 echoed pops → `err_ct_o`=0, `bit_ct_o`=64.
- Underflow: `dec_valid_i` with FIFO empty → `udf_o`=1, `bit_ct_o` unchanged. Simultaneous push+pop on empty → `level_o`=1.
- SKIP=4: 10 matched pairs → first 4 uncounted, `checking_o` rises after 4th pop, `bit_ct_o`=6.
